mult32_seq: RTL
===============

Name: mult32_seq

Overview:
Iterative 32x32 shift-and-add multiplier that sits beside the ALU logic/arithmetic units in the datapath. It consumes the same OP1/OP2 operands and produces a 64-bit product as HI/LO, plus a zero flag for the result mux and flag logic. It is multi-cycle and uses a START/BUSY/DONE handshake to the control unit.

Parameters:
DATA_WIDTH, 32, operand width. Product is 2*DATA_WIDTH bits; the iteration count equals DATA_WIDTH.

Ports:
CLK  input  1  clock; all state updates on the rising edge
RST  input  1  asynchronous active-low reset
START  input  1  request pulse; sampled only in IDLE
SIGNED  input  1  1 = two's-complement multiply, 0 = unsigned; sampled with START
OP1  input  DATA_WIDTH  multiplicand; sampled with START
OP2  input  DATA_WIDTH  multiplier; sampled with START
BUSY  output  1  high while an operation is in progress
DONE  output  1  one-cycle pulse when HI/LO update
HI  output  DATA_WIDTH  upper half of the product
LO  output  DATA_WIDTH  lower half of the product
ZERO  output  1  1 when the full 64-bit product is 0

Behaviour:
- Interface: one clock, CLK. RST is asynchronous and active-low.
- Reset (RST=0, any time, including mid-operation):
  - state goes to IDLE immediately;
  - BUSY=0, DONE=0, HI=0, LO=0, ZERO=1;
  - counter, accumulator and working registers are cleared;
  - an in-flight operation is discarded; no DONE is produced.
- States: IDLE, RUN, FIN.
- IDLE:
  - START=1 at edge E0 captures operands and the sign flags.
  - SIGNED=1: the magnitudes |OP1| and |OP2| are loaded; neg = OP1[31] XOR OP2[31].
  - SIGNED=0: operands are loaded as-is; neg = 0.
  - mcand (64b) = zero-extended |OP1|; mplier (32b) = |OP2|; acc (64b) = 0; count = 0; next state RUN; BUSY=1 from E0.
- RUN, each edge:
  - if mplier[0]=1, acc += mcand (64-bit add; carry out discarded, cannot overflow);
  - mcand <<= 1; mplier >>= 1; count += 1;
  - the edge with count == DATA_WIDTH-1 moves to FIN.
  - RUN therefore lasts exactly 32 edges (E1..E32).
- FIN (edge E33):
  - {HI,LO} = neg ? (~acc + 1) : acc;
  - ZERO = ~|{HI,LO}|;
  - DONE=1 for exactly this one cycle; BUSY=0; next state IDLE.
- Latency: START sampled at E0 -> DONE high and results valid after E33, i.e. 33 cycles.
- Results hold: HI/LO/ZERO keep their last value until the next FIN or reset. They do not change during RUN.
- START in RUN or FIN: ignored, no queueing. START sampled in the same cycle DONE is high: state is FIN, so it is ignored.
- Back-to-back: START held high continuously restarts one cycle after DONE (IDLE edge).
- Signed corner: |0x80000000| = 0x80000000 interpreted unsigned. The magnitude path is 32-bit unsigned, so no overflow.
- Operand changes after E0 have no effect.

Optional Feature:
MULT_EARLY_TERM_EN
- Defined: in RUN, if mplier == 0 after the current shift, the next state is FIN regardless of count. Latency becomes (index of highest set bit of |OP2|) + 2 cycles. OP2 = 0 goes E0 -> RUN (1 edge) -> FIN, so DONE comes 2 cycles after START. Results are identical to the full run.
- Undefined: fixed 33-cycle latency for every operand.

Test Plan:
- Unsigned max: SIGNED=0, OP1=OP2=0xFFFFFFFF, pulse START -> after 33 cycles DONE=1 for 1 cycle; HI=0xFFFFFFFE, LO=0x00000001, ZERO=0; BUSY high for exactly 33 cycles.
- Signed mix: SIGNED=1, OP1=0xFFFFFFFF (-1), OP2=0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFF9. Also OP1=OP2=0x80000000 -> HI=0x40000000, LO=0x00000000.
- Zero flag: OP1=0x12345678, OP2=0 -> HI=LO=0, ZERO=1. With MULT_EARLY_TERM_EN, DONE comes 2 cycles after START.
- Ignored START: start 3x5 (unsigned), pulse START with OP1=9, OP2=9 at cycle 10 -> single DONE at cycle 33 with LO=15, and no second operation.
- Reset mid-op: start 0x10000*0x10000, drive RST=0 at cycle 20 (asynchronously, between edges) -> outputs go to reset values immediately, no DONE follows. After release, 2*3 yields LO=6, HI=0.
- Back-to-back with START held high: 6*7 then 0xFFFFFFFE*2 signed -> DONE pulses 34 cycles apart; LO=42, then HI=0xFFFFFFFF, LO=0xFFFFFFFC.

Source files
------------

// File: rtl/mult32_seq.sv
// Iterative shift-and-add multiplier producing a 2*DATA_WIDTH product as HI/LO with a zero flag.
// Optional `MULT_EARLY_TERM_EN: leave RUN as soon as the remaining multiplier bits are all zero.
module mult32_seq #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  SIGNED,
    input  logic [DATA_WIDTH-1:0] OP1,
    input  logic [DATA_WIDTH-1:0] OP2,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [DATA_WIDTH-1:0] HI,
    output logic [DATA_WIDTH-1:0] LO,
    output logic                  ZERO
);

    localparam int unsigned CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t                    state, state_nx;
    logic [2*DATA_WIDTH-1:0]   mcand;
    logic [2*DATA_WIDTH-1:0]   acc;
    logic [DATA_WIDTH-1:0]     mplier;
    logic [CW-1:0]             count;
    logic                      neg;
    logic [DATA_WIDTH-1:0]     hi, lo;
    logic                      zero;
    logic                      done;

    logic [DATA_WIDTH-1:0]     mag1, mag2;
    logic [DATA_WIDTH-1:0]     mplier_sh;
    logic [2*DATA_WIDTH-1:0]   acc_add;
    logic [2*DATA_WIDTH-1:0]   res;

    // Magnitudes are unsigned DATA_WIDTH values, so the most negative operand maps cleanly.
    always_comb begin
        mag1      = (SIGNED && OP1[DATA_WIDTH-1]) ? ('0 - OP1) : OP1;
        mag2      = (SIGNED && OP2[DATA_WIDTH-1]) ? ('0 - OP2) : OP2;
        mplier_sh = mplier >> 1;
        acc_add   = mplier[0] ? (acc + mcand) : acc;
        res       = neg ? ('0 - acc) : acc;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (START) state_nx = RUN;
            RUN: begin
`ifdef MULT_EARLY_TERM_EN
                if (count == LAST || mplier_sh == '0) state_nx = FIN;
`else
                if (count == LAST) state_nx = FIN;
`endif
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state  <= IDLE;
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            count  <= '0;
            neg    <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            zero   <= 1'b1;
            done   <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        mcand  <= {{DATA_WIDTH{1'b0}}, mag1};
                        mplier <= mag2;
                        acc    <= '0;
                        count  <= '0;
                        neg    <= SIGNED & (OP1[DATA_WIDTH-1] ^ OP2[DATA_WIDTH-1]);
                    end
                end
                RUN: begin
                    acc    <= acc_add;
                    mcand  <= mcand << 1;
                    mplier <= mplier_sh;
                    count  <= count + CW'(1);
                end
                FIN: begin
                    {hi, lo} <= res;
                    zero     <= ~|res;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign BUSY = (state != IDLE);
    assign DONE = done;
    assign HI   = hi;
    assign LO   = lo;
    assign ZERO = zero;

endmodule
